// File: rtl/fp_add_sub_issue_ctrl.sv
// Issue controller for the 3-stage fadd_sub unit: shadow pipeline, RAW/WAW hazard check, flush and drain.
// Optional FP_ADD_SUB_ISSUE_BYPASS_EN: S2 result is forwarded, so S2 is left out of the RAW check.
module fp_add_sub_issue_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       flush,
  input  logic       drain_req,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [4:0] issue_rs1,
  input  logic [4:0] issue_rs2,
  input  logic       issue_rs1_fp,
  input  logic       issue_rs2_fp,
  input  logic [4:0] issue_rd,
  input  logic       issue_fp_wr,
  output logic       p_start,
  output logic [2:0] clear,
  output logic       hazard,
  output logic [1:0] inflight_cnt,
  output logic       drain_done
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

`ifdef FP_ADD_SUB_ISSUE_BYPASS_EN
  localparam logic [2:0] RAW_MASK = 3'b011;
`else
  localparam logic [2:0] RAW_MASK = 3'b111;
`endif

  state_t     state;
  logic [2:0] s_valid;
  logic [2:0] s_fp_wr;
  logic [4:0] s_rd [3];
  logic       hz_any;

  always_comb begin
    hz_any = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (s_valid[k] && s_fp_wr[k]) begin
        if (RAW_MASK[k] && ((issue_rs1_fp && s_rd[k] == issue_rs1) ||
                            (issue_rs2_fp && s_rd[k] == issue_rs2)))
          hz_any = 1'b1;
        if (issue_fp_wr && s_rd[k] == issue_rd)
          hz_any = 1'b1;
      end
    end
  end

  assign hazard       = issue_valid & hz_any;
  // Combinational outputs are forced low while rst is held.
  assign issue_ready  = ~rst & en & ~hazard & ~flush & (state == RUN);
  assign p_start      = issue_valid & issue_ready;
  assign clear        = {3{flush & ~rst}};
  assign inflight_cnt = {1'b0, s_valid[0]} + {1'b0, s_valid[1]} + {1'b0, s_valid[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= '0;
      s_fp_wr <= '0;
      for (int unsigned k = 0; k < 3; k++) s_rd[k] <= '0;
    end else if (flush) begin
      s_valid <= '0;
    end else if (en) begin
      s_valid <= {s_valid[1:0], p_start};
      s_fp_wr <= {s_fp_wr[1:0], issue_fp_wr};
      s_rd[0] <= issue_rd;
      s_rd[1] <= s_rd[0];
      s_rd[2] <= s_rd[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        RUN:   if (drain_req) state <= DRAIN;
        DRAIN: if (inflight_cnt == 2'd0) begin
                 state      <= DONE;
                 drain_done <= 1'b1;
               end
        DONE:  if (!drain_req) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sub_issue_ctrl.sv
// Scoreboard bench for fp_add_sub_issue_ctrl: per-cycle expected outputs are queued by the stimulus
// and checked by an independent monitor on the falling edge.
module tb_fp_add_sub_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, flush, drain_req, iv, rs1fp, rs2fp, fpwr;
  logic [4:0] rs1, rs2, rd;
  logic       issue_ready, p_start, hazard, drain_done;
  logic [2:0] clear;
  logic [1:0] inflight_cnt;

  typedef struct {
    string      name;
    logic       rdy;
    logic       ps;
    logic [2:0] clr;
    logic       hz;
    logic [1:0] cnt;
    logic       dd;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;

  fp_add_sub_issue_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .drain_req(drain_req),
    .issue_valid(iv), .issue_ready(issue_ready),
    .issue_rs1(rs1), .issue_rs2(rs2), .issue_rs1_fp(rs1fp), .issue_rs2_fp(rs2fp),
    .issue_rd(rd), .issue_fp_wr(fpwr),
    .p_start(p_start), .clear(clear), .hazard(hazard),
    .inflight_cnt(inflight_cnt), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int exp_v);
    ntests++;
    if (act != exp_v) begin
      nfail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "issue_ready",  int'(issue_ready),  int'(e.rdy));
        chk(e.name, "p_start",      int'(p_start),      int'(e.ps));
        chk(e.name, "clear",        int'(clear),        int'(e.clr));
        chk(e.name, "hazard",       int'(hazard),       int'(e.hz));
        chk(e.name, "inflight_cnt", int'(inflight_cnt), int'(e.cnt));
        chk(e.name, "drain_done",   int'(drain_done),   int'(e.dd));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic step(input string nm, input logic r, input logic p, input logic [2:0] c,
                      input logic h, input logic [1:0] n, input logic d);
    exp_t e;
    e.name = nm; e.rdy = r; e.ps = p; e.clr = c; e.hz = h; e.cnt = n; e.dd = d;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic [4:0] d, input logic w, input logic [4:0] a, input logic af,
                     input logic [4:0] b, input logic bf);
    iv = 1'b1; rd = d; fpwr = w; rs1 = a; rs1fp = af; rs2 = b; rs2fp = bf;
  endtask

  task automatic noiss();
    iv = 1'b0; rd = '0; fpwr = 1'b0; rs1 = '0; rs1fp = 1'b0; rs2 = '0; rs2fp = 1'b0;
  endtask

  task automatic idle(input string nm, input logic [1:0] n);
    noiss();
    step(nm, 1'b1, 1'b0, 3'b000, 1'b0, n, 1'b0);
  endtask

  initial begin : stim
    rst = 1'b1; en = 1'b1; flush = 1'b1; drain_req = 1'b1;
    iss(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;

    // Reset holds every output low even with active inputs
    step("rst0", 0, 0, 3'b000, 0, 0, 0);
    flush = 1'b0; drain_req = 1'b0;
    step("rst1", 0, 0, 3'b000, 0, 0, 0);
    step("rst2", 0, 0, 3'b000, 0, 0, 0);

    // First accept right after reset, then occupancy 1,2,3,0
    rst = 1'b0;
    iss(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step("a_accept", 1, 1, 3'b000, 0, 0, 0);
    idle("a_cnt1", 1); idle("a_cnt2", 1); idle("a_cnt3", 1); idle("a_cnt0", 0);

    // RAW on rs1
    iss(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step("b_issue", 1, 1, 3'b000, 0, 0, 0);
    iss(5'd10, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
    step("b_raw_s0", 0, 0, 3'b000, 1, 1, 0);
    step("b_raw_s1", 0, 0, 3'b000, 1, 1, 0);
`ifdef FP_ADD_SUB_ISSUE_BYPASS_EN
    step("b_bypass_accept", 1, 1, 3'b000, 0, 1, 0);
    idle("b_d1", 1); idle("b_d2", 1); idle("b_d3", 1); idle("b_d4", 0);
`else
    step("b_raw_s2", 0, 0, 3'b000, 1, 1, 0);
    step("b_accept", 1, 1, 3'b000, 0, 0, 0);
    idle("b_d1", 1); idle("b_d2", 1); idle("b_d3", 1); idle("b_d4", 0);
`endif

    // Back-to-back issues then flush
    iss(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("c_i1", 1, 1, 3'b000, 0, 0, 0);
    iss(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("c_i2", 1, 1, 3'b000, 0, 1, 0);
    iss(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("c_i3", 1, 1, 3'b000, 0, 2, 0);
    flush = 1'b1;
    iss(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("c_flush", 0, 0, 3'b111, 0, 3, 0);
    flush = 1'b0;
    iss(5'd4, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0); step("c_after", 1, 1, 3'b000, 0, 0, 0);
    idle("c_d1", 1); idle("c_d2", 1); idle("c_d3", 1); idle("c_d4", 0);

    // Stall with two in flight
    iss(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("d_i1", 1, 1, 3'b000, 0, 0, 0);
    iss(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("d_i2", 1, 1, 3'b000, 0, 1, 0);
    en = 1'b0;
    iss(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("d_stall1", 0, 0, 3'b000, 0, 2, 0);
    step("d_stall2", 0, 0, 3'b000, 0, 2, 0);
    en = 1'b1;
    idle("d_r1", 2); idle("d_r2", 2); idle("d_r3", 1); idle("d_r4", 0);

    // WAW on S1/S2, then integer destination excluded
    iss(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("e_issue", 1, 1, 3'b000, 0, 0, 0);
    idle("e_gap", 1);
    iss(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("e_waw_s1", 0, 0, 3'b000, 1, 1, 0);
    step("e_waw_s2", 0, 0, 3'b000, 1, 1, 0);
    idle("e_empty", 0);
    iss(5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); step("e_int", 1, 1, 3'b000, 0, 0, 0);
    iss(5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0); step("e_int_nohz", 1, 1, 3'b000, 0, 1, 0);
    idle("e_d1", 2); idle("e_d2", 2); idle("e_d3", 1); idle("e_d4", 0);

    // RAW on rs2, and rs2 from integer file ignored
    iss(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("r2_issue", 1, 1, 3'b000, 0, 0, 0);
    iss(5'd12, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1); step("r2_raw", 0, 0, 3'b000, 1, 1, 0);
    iss(5'd12, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0); step("r2_intsrc", 1, 1, 3'b000, 0, 1, 0);
    idle("r2_d1", 2); idle("r2_d2", 1); idle("r2_d3", 1); idle("r2_d4", 0);

    // Drain with three in flight
    iss(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("f_i1", 1, 1, 3'b000, 0, 0, 0);
    iss(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("f_i2", 1, 1, 3'b000, 0, 1, 0);
    drain_req = 1'b1;
    iss(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("f_i3", 1, 1, 3'b000, 0, 2, 0);
    iss(5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("f_drain3", 0, 0, 3'b000, 0, 3, 0);
    step("f_drain2", 0, 0, 3'b000, 0, 2, 0);
    step("f_drain1", 0, 0, 3'b000, 0, 1, 0);
    step("f_drain0", 0, 0, 3'b000, 0, 0, 0);
    step("f_done", 0, 0, 3'b000, 0, 0, 1);
    drain_req = 1'b0;
    step("f_done_hold", 0, 0, 3'b000, 0, 0, 0);
    step("f_run", 1, 1, 3'b000, 0, 0, 0);
    idle("f_d1", 1); idle("f_d2", 1); idle("f_d3", 1); idle("f_d4", 0);

    // Drain from empty: pulse two cycles after request
    drain_req = 1'b1;
    idle("g_req", 0);
    noiss(); step("g_drain", 0, 0, 3'b000, 0, 0, 0);
    drain_req = 1'b0;
    step("g_done", 0, 0, 3'b000, 0, 0, 1);
    idle("g_run", 0);

    // Flush while draining
    iss(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("h_i1", 1, 1, 3'b000, 0, 0, 0);
    drain_req = 1'b1;
    iss(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("h_i2", 1, 1, 3'b000, 0, 1, 0);
    flush = 1'b1; noiss();
    step("h_flush", 0, 0, 3'b111, 0, 2, 0);
    flush = 1'b0;
    step("h_empty", 0, 0, 3'b000, 0, 0, 0);
    drain_req = 1'b0;
    step("h_done", 0, 0, 3'b000, 0, 0, 1);
    idle("h_run", 0);

    // Reset mid-drain discards tracking without a drain_done pulse
    iss(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("i_i1", 1, 1, 3'b000, 0, 0, 0);
    iss(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("i_i2", 1, 1, 3'b000, 0, 1, 0);
    drain_req = 1'b1;
    idle("i_req", 2);
    rst = 1'b1;
    iss(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step("i_rst", 0, 0, 3'b000, 0, 0, 0);
    rst = 1'b0; drain_req = 1'b0;
    step("i_accept", 1, 1, 3'b000, 0, 0, 0);
    idle("i_d1", 1); idle("i_d2", 1); idle("i_d3", 1); idle("i_d4", 0);

    repeat (2) @(negedge clk);
    ntests++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
